// File: rtl/ni_injection_packetizer_if.sv
// Bundle of descriptor, payload-word and router-facing flit signals for the
// injection packetizer. "master" is the packetizer side, "slave" the environment.
interface ni_injection_packetizer_if #(
    parameter int PAYLOAD_W = 32,
    parameter int COORD_W   = 3,
    parameter int MAX_LEN   = 15,
    parameter int LEN_W     = $clog2(MAX_LEN + 1),
    parameter int FLIT_W    = PAYLOAD_W + 2
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready
    // (descriptor, payload word) or o_upstream_req && i_on_off (flit). A
    // pending flit holds o_flit/o_upstream_req stable until it is consumed.
    logic                 i_msg_valid;
    logic                 o_msg_ready;
    logic [COORD_W-1:0]   i_msg_dst_x;
    logic [COORD_W-1:0]   i_msg_dst_y;
    logic [LEN_W-1:0]     i_msg_len;
    logic                 i_word_valid;
    logic                 o_word_ready;
    logic [PAYLOAD_W-1:0] i_word_data;
    logic [FLIT_W-1:0]    o_flit;
    logic                 o_upstream_req;
    logic                 i_on_off;
    logic                 o_len_err;
    logic [15:0]          o_pkt_cnt;
    logic                 dbg_state;

    modport master (
        input  i_msg_valid, i_msg_dst_x, i_msg_dst_y, i_msg_len,
        input  i_word_valid, i_word_data, i_on_off,
        output o_msg_ready, o_word_ready, o_flit, o_upstream_req,
        output o_len_err, o_pkt_cnt, dbg_state
    );

    modport slave (
        output i_msg_valid, i_msg_dst_x, i_msg_dst_y, i_msg_len,
        output i_word_valid, i_word_data, i_on_off,
        input  o_msg_ready, o_word_ready, o_flit, o_upstream_req,
        input  o_len_err, o_pkt_cnt, dbg_state
    );
endinterface

// File: rtl/ni_injection_packetizer.sv
// Network-interface injection stage: turns a descriptor plus payload words into
// a HEAD / BODY... / TAIL flit packet, with a single-entry output register.
module ni_injection_packetizer #(
    parameter int PAYLOAD_W = 32,
    parameter int COORD_W   = 3,
    parameter int MAX_LEN   = 15,
    parameter int LEN_W     = $clog2(MAX_LEN + 1),
    parameter int SRC_X     = 0,
    parameter int SRC_Y     = 0,
    parameter int FLIT_W    = PAYLOAD_W + 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    ni_injection_packetizer_if.master   bus
);
    localparam logic [1:0] T_HEAD      = 2'b00;
    localparam logic [1:0] T_BODY      = 2'b01;
    localparam logic [1:0] T_TAIL      = 2'b10;
    localparam logic [1:0] T_HEAD_TAIL = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t               state;
    logic [LEN_W-1:0]     rem;
    logic                 slot_free;
    logic                 msg_fire;
    logic                 word_fire;
    logic                 flit_fire;
    logic                 len_bad;
    logic                 last_word;
    logic [PAYLOAD_W-1:0] head_payload;

    // The output register can take a new flit when empty or being drained now.
    assign slot_free = !bus.o_upstream_req || bus.i_on_off;

    assign bus.o_msg_ready  = reset_n && (state == IDLE) && slot_free;
    assign bus.o_word_ready = reset_n && (state == BODY) && slot_free;
    assign bus.dbg_state    = state;

    assign msg_fire  = bus.i_msg_valid && bus.o_msg_ready;
    assign word_fire = bus.i_word_valid && bus.o_word_ready;
    assign flit_fire = bus.o_upstream_req && bus.i_on_off;
    assign len_bad   = 32'(bus.i_msg_len) > 32'(MAX_LEN);
    assign last_word = (rem == LEN_W'(1));

    assign head_payload = PAYLOAD_W'({bus.i_msg_dst_x, bus.i_msg_dst_y,
                                      COORD_W'(SRC_X), COORD_W'(SRC_Y),
                                      bus.i_msg_len});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            rem                <= '0;
            bus.o_flit         <= '0;
            bus.o_upstream_req <= 1'b0;
            bus.o_len_err      <= 1'b0;
            bus.o_pkt_cnt      <= '0;
        end else begin
            bus.o_len_err <= 1'b0;

            // Type bit 1 set means TAIL or HEAD_TAIL: the packet is complete.
            if (flit_fire) begin
                bus.o_upstream_req <= 1'b0;
                if (bus.o_flit[FLIT_W-1])
                    bus.o_pkt_cnt <= bus.o_pkt_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (msg_fire) begin
                        if (len_bad) begin
                            bus.o_len_err <= 1'b1;
                        end else if (bus.i_msg_len == '0) begin
                            bus.o_flit         <= {T_HEAD_TAIL, head_payload};
                            bus.o_upstream_req <= 1'b1;
                        end else begin
                            bus.o_flit         <= {T_HEAD, head_payload};
                            bus.o_upstream_req <= 1'b1;
                            rem                <= bus.i_msg_len;
                            state              <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (word_fire) begin
                        bus.o_flit         <= {last_word ? T_TAIL : T_BODY, bus.i_word_data};
                        bus.o_upstream_req <= 1'b1;
                        rem                <= rem - LEN_W'(1);
                        if (last_word)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
